// File: rtl/custom_pkg.sv
// Shared constants for the rv32 multi-cycle core: immediate formats, ALU ops,
// control FSM state encoding, datapath select codes and RV32I opcodes.
package custom_pkg;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_R   = 2'd1,
        ALU_CLS_I   = 2'd2
    } alu_cls_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ALU_A_RS1   = 2'd0;
    localparam logic [1:0] ALU_A_PC    = 2'd1;
    localparam logic [1:0] ALU_A_OLDPC = 2'd2;
    localparam logic [1:0] ALU_A_ZERO  = 2'd3;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// alu_dec: combinational map from (alu class, funct3, funct7_5) to ALU op code.
module alu_dec
    import custom_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (cls != ALU_CLS_ADD) begin
            case (funct3)
                3'b000:  alu_op = (cls == ALU_CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the rv32 multi-cycle core (fetch/decode/execute/mem/wb).
// Define CTRL_ILLEGAL_TRAP_EN to add a sticky TRAP state for illegal opcodes.
module mc_ctrl_fsm
    import custom_pkg::*;
#(
    parameter int unsigned FENCE_AS_NOP = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       cmp_true_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       sel_addr_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic       sel_pc_o,
    output logic       rf_we_o,
    output logic [1:0] sel_wb_o,
    output logic [1:0] sel_alu_a_o,
    output logic [1:0] sel_alu_b_o,
    output logic [3:0] alu_op_o,
    output logic [2:0] sel_imm_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam ctrl_state_e ILLEGAL_NEXT = S_TRAP;
`else
    localparam ctrl_state_e ILLEGAL_NEXT = S_FETCH;
`endif
    localparam ctrl_state_e SYS_NEXT = ctrl_state_e'((FENCE_AS_NOP != 0) ? S_FETCH : ILLEGAL_NEXT);

    ctrl_state_e state, next;
    alu_cls_e    alu_cls;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  if (mem_ready_i) next = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OPC_LOAD, OPC_STORE:   next = S_MEM_ADDR;
                    OPC_OP:                next = S_EXEC_R;
                    OPC_OPIMM:             next = S_EXEC_I;
                    OPC_BRANCH:            next = S_BRANCH;
                    OPC_JAL:               next = S_JAL;
                    OPC_JALR:              next = S_JALR;
                    OPC_LUI:               next = S_LUI;
                    OPC_AUIPC:             next = S_AUIPC;
                    OPC_FENCE, OPC_SYSTEM: next = SYS_NEXT;
                    default:               next = ILLEGAL_NEXT;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next = S_ALU_WB;
            S_MEM_ADDR: next = (opcode_i == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:     next = S_TRAP;
`endif
            default:    next = S_FETCH;
        endcase
    end

    // Gated by rst_i so a reset mid-access drops the request before any edge.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        sel_addr_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        sel_pc_o    = 1'b0;
        rf_we_o     = 1'b0;
        sel_wb_o    = WB_ALU;
        sel_alu_a_o = ALU_A_RS1;
        sel_alu_b_o = ALU_B_RS2;
        sel_imm_o   = IMM_I;
        alu_cls     = ALU_CLS_ADD;
        if (!rst_i) begin
            case (state)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    sel_alu_a_o = ALU_A_PC;
                    sel_alu_b_o = ALU_B_FOUR;
                    ir_we_o     = mem_ready_i;
                    pc_we_o     = mem_ready_i;
                end
                S_DECODE: begin
                    sel_alu_a_o = ALU_A_OLDPC;
                    sel_alu_b_o = ALU_B_IMM;
                    sel_imm_o   = IMM_B;
                end
                S_EXEC_R: alu_cls = ALU_CLS_R;
                S_EXEC_I: begin
                    sel_alu_b_o = ALU_B_IMM;
                    alu_cls     = ALU_CLS_I;
                end
                S_ALU_WB: rf_we_o = 1'b1;
                S_MEM_ADDR: begin
                    sel_alu_b_o = ALU_B_IMM;
                    sel_imm_o   = (opcode_i == OPC_STORE) ? IMM_S : IMM_I;
                end
                S_MEM_RD: begin
                    mem_req_o  = 1'b1;
                    sel_addr_o = 1'b1;
                end
                S_MEM_WB: begin
                    rf_we_o  = 1'b1;
                    sel_wb_o = WB_MEM;
                end
                S_MEM_WR: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    sel_addr_o = 1'b1;
                end
                S_BRANCH: begin
                    pc_we_o  = cmp_true_i;
                    sel_pc_o = cmp_true_i;
                end
                S_JAL, S_JALR: begin
                    sel_alu_a_o = (state == S_JAL) ? ALU_A_OLDPC : ALU_A_RS1;
                    sel_alu_b_o = ALU_B_IMM;
                    sel_imm_o   = (state == S_JAL) ? IMM_J : IMM_I;
                    pc_we_o     = 1'b1;
                    rf_we_o     = 1'b1;
                    sel_wb_o    = WB_PC4;
                end
                S_LUI, S_AUIPC: begin
                    sel_alu_a_o = (state == S_LUI) ? ALU_A_ZERO : ALU_A_OLDPC;
                    sel_alu_b_o = ALU_B_IMM;
                    sel_imm_o   = IMM_U;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_o = (state == S_TRAP);
`else
    assign illegal_o = 1'b0;
`endif

    assign state_o = state;

    alu_dec u_alu_dec (
        .cls      (alu_cls),
        .funct3   (funct3_i),
        .funct7_5 (funct7_5_i),
        .alu_op   (alu_op_o)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; expectations are hand-computed
// constants. Also builds with CTRL_ILLEGAL_TRAP_EN defined.
module tb_mc_ctrl_fsm;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADDR = 4'd2,
                           ST_MEM_RD = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WR = 4'd5,
                           ST_EXEC_R = 4'd6, ST_EXEC_I = 4'd7, ST_ALU_WB = 4'd8,
                           ST_BRANCH = 4'd9, ST_JAL = 4'd10, ST_JALR = 4'd11,
                           ST_LUI = 4'd12, ST_AUIPC = 4'd13, ST_TRAP = 4'd14;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5, cmp_true, mem_ready;
    logic       mem_req_o, mem_we_o, sel_addr_o, ir_we_o, pc_we_o, sel_pc_o, rf_we_o, illegal_o;
    logic [1:0] sel_wb_o, sel_alu_a_o, sel_alu_b_o;
    logic [3:0] alu_op_o, state_o;
    logic [2:0] sel_imm_o;
    logic [7:0] en;

    always #5 clk = ~clk;

    // {mem_req, mem_we, sel_addr, ir_we, pc_we, sel_pc, rf_we, illegal}
    assign en = {mem_req_o, mem_we_o, sel_addr_o, ir_we_o, pc_we_o, sel_pc_o, rf_we_o, illegal_o};

    mc_ctrl_fsm #(.FENCE_AS_NOP(1)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_5_i  (funct7_5),
        .cmp_true_i  (cmp_true),
        .mem_ready_i (mem_ready),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .sel_addr_o  (sel_addr_o),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .sel_pc_o    (sel_pc_o),
        .rf_we_o     (rf_we_o),
        .sel_wb_o    (sel_wb_o),
        .sel_alu_a_o (sel_alu_a_o),
        .sel_alu_b_o (sel_alu_b_o),
        .alu_op_o    (alu_op_o),
        .sel_imm_o   (sel_imm_o),
        .illegal_o   (illegal_o),
        .state_o     (state_o)
    );

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cyc(input logic rdy, input logic cmp);
        @(negedge clk);
        mem_ready = rdy;
        cmp_true  = cmp;
        #1;
    endtask

    // Zero-wait FETCH then DECODE; returns sampled in the DECODE cycle.
    task automatic fd(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        @(negedge clk);
        opcode = op; funct3 = f3; funct7_5 = f7; mem_ready = 1'b1; cmp_true = 1'b0;
        #1;
        chk("fetch_state", state_o, ST_FETCH);
        chk("fetch_en", en, 8'h98);
        chk("fetch_alu", {sel_alu_a_o, sel_alu_b_o, alu_op_o}, 8'h60);
        cyc(1'b0, 1'b0);
        chk("dec_state", state_o, ST_DECODE);
        chk("dec_en", en, 8'h00);
        chk("dec_imm", sel_imm_o, 3'd2);
        chk("dec_ab", {sel_alu_a_o, sel_alu_b_o}, 4'b1001);
    endtask

    logic [2:0] rf3 [10] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b101, 3'b110, 3'b111};
    logic       rf7 [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] rop [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; cmp_true = 1'b0; mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("rst_state", state_o, ST_FETCH);
        chk("rst_en", en, 8'h00);
        chk("rst_sel", {sel_wb_o, sel_alu_a_o, sel_alu_b_o, alu_op_o, sel_imm_o}, 13'h0);
        @(negedge clk); rst = 1'b0;

        // ADDI with funct7_5 set must still add
        fd(7'b0010011, 3'b000, 1'b1);
        cyc(1'b0, 1'b0);
        chk("addi_state", state_o, ST_EXEC_I);
        chk("addi_en", en, 8'h00);
        chk("addi_imm", sel_imm_o, 3'd0);
        chk("addi_alu", {sel_alu_a_o, sel_alu_b_o, alu_op_o}, 8'h10);
        cyc(1'b0, 1'b0);
        chk("addi_wb_state", state_o, ST_ALU_WB);
        chk("addi_wb_en", en, 8'h02);
        chk("addi_wb_sel", sel_wb_o, 2'd0);

        fd(7'b0010011, 3'b101, 1'b1);
        cyc(1'b0, 1'b0);
        chk("srai_op", alu_op_o, 4'd7);
        cyc(1'b0, 1'b0);

        for (int unsigned i = 0; i < 10; i++) begin
            fd(7'b0110011, rf3[i], rf7[i]);
            cyc(1'b0, 1'b0);
            chk("execr_state", state_o, ST_EXEC_R);
            chk("execr_op", alu_op_o, rop[i]);
            chk("execr_ab", {sel_alu_a_o, sel_alu_b_o}, 4'b0000);
            cyc(1'b0, 1'b0);
            chk("execr_wb_en", en, 8'h02);
        end

        // LW with 3 wait cycles in MEM_RD
        fd(7'b0000011, 3'b010, 1'b0);
        cyc(1'b0, 1'b0);
        chk("lw_addr_state", state_o, ST_MEM_ADDR);
        chk("lw_addr_imm", sel_imm_o, 3'd0);
        chk("lw_addr_alu", {sel_alu_a_o, sel_alu_b_o, alu_op_o}, 8'h10);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            chk("lw_wait_state", state_o, ST_MEM_RD);
            chk("lw_wait_en", en, 8'hA0);
        end
        cyc(1'b1, 1'b0);
        chk("lw_rdy_state", state_o, ST_MEM_RD);
        chk("lw_rdy_en", en, 8'hA0);
        cyc(1'b0, 1'b0);
        chk("lw_wb_state", state_o, ST_MEM_WB);
        chk("lw_wb_en", en, 8'h02);
        chk("lw_wb_sel", sel_wb_o, 2'd1);

        fd(7'b0100011, 3'b010, 1'b0);
        cyc(1'b0, 1'b0);
        chk("sw_addr_imm", sel_imm_o, 3'd1);
        cyc(1'b1, 1'b0);
        chk("sw_wr_state", state_o, ST_MEM_WR);
        chk("sw_wr_en", en, 8'hE0);

        fd(7'b1100011, 3'b000, 1'b0);
        cyc(1'b0, 1'b1);
        chk("beq_t_state", state_o, ST_BRANCH);
        chk("beq_t_en", en, 8'h0C);
        chk("beq_t_ab", {sel_alu_a_o, sel_alu_b_o}, 4'b0000);
        fd(7'b1100011, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("beq_nt_en", en, 8'h00);

        fd(7'b1101111, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("jal_state", state_o, ST_JAL);
        chk("jal_en", en, 8'h0A);
        chk("jal_imm", sel_imm_o, 3'd4);
        chk("jal_wb", sel_wb_o, 2'd2);
        chk("jal_ab", {sel_alu_a_o, sel_alu_b_o}, 4'b1001);

        fd(7'b1100111, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("jalr_state", state_o, ST_JALR);
        chk("jalr_en", en, 8'h0A);
        chk("jalr_sel", {sel_alu_a_o, sel_imm_o}, 5'b00000);

        fd(7'b0110111, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("lui_state", state_o, ST_LUI);
        chk("lui_sel", {sel_alu_a_o, sel_alu_b_o, sel_imm_o}, 7'b1101011);
        cyc(1'b0, 1'b0);
        chk("lui_wb_state", state_o, ST_ALU_WB);

        fd(7'b0010111, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("auipc_state", state_o, ST_AUIPC);
        chk("auipc_sel", {sel_alu_a_o, sel_alu_b_o, sel_imm_o}, 7'b1001011);
        cyc(1'b0, 1'b0);
        chk("auipc_wb_state", state_o, ST_ALU_WB);

        fd(7'b0001111, 3'b000, 1'b0);
        cyc(1'b0, 1'b0);
        chk("fence_state", state_o, ST_FETCH);
        chk("fence_en", en, 8'h80);

        // async reset during FETCH wait, no clock edge in between
        #2 rst = 1'b1;
        #1;
        chk("rstf_state", state_o, ST_FETCH);
        chk("rstf_en", en, 8'h00);
        chk("rstf_sel", {sel_alu_a_o, sel_alu_b_o}, 4'b0000);
        @(negedge clk); rst = 1'b0;

        // async reset during MEM_RD wait
        fd(7'b0000011, 3'b010, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("rstm_pre_state", state_o, ST_MEM_RD);
        #2 rst = 1'b1;
        #1;
        chk("rstm_state", state_o, ST_FETCH);
        chk("rstm_en", en, 8'h00);
        @(negedge clk); rst = 1'b0;

        fd(7'b0000000, 3'b000, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0);
            chk("trap_state", state_o, ST_TRAP);
            chk("trap_en", en, 8'h01);
        end
        #2 rst = 1'b1;
        #1;
        chk("trap_rst_state", state_o, ST_FETCH);
        chk("trap_rst_en", en, 8'h00);
`else
        cyc(1'b0, 1'b0);
        chk("ill_state", state_o, ST_FETCH);
        chk("ill_en", en, 8'h80);
        cyc(1'b0, 1'b0);
        chk("ill_hold_state", state_o, ST_FETCH);
        chk("ill_hold_illegal", illegal_o, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
